serial_sub_ctrl: RTL and testbench

// - Bit-serial N-bit subtractor controller: computes diff = A - B, LSB first, one bit per clock.
// - Drives the team's 1-bit full subtractor cell full_sb (a,b,c -> d,bo) each cycle and feeds its bo back as the next borrow-in.
// - Sits upstream and downstream of full_sb. Gives datapath blocks a small-area subtract behind a valid/ready handshake.

---
 rtl/serial_sub_ctrl_pkg.sv | 13 +
 rtl/serial_sub_ctrl_full_sb.sv | 14 +
 rtl/serial_sub_ctrl.sv | 97 +++++++++
 tb/tb_serial_sub_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller.
// State encoding and the widest supported operand width.
package serial_sub_ctrl_pkg;

    localparam int SUB_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_sb.sv
// One-bit full subtractor cell: d = a - b - c, bo = borrow out.
// Used once per cycle by the serial subtract controller.
module full_sb (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ c;
    assign bo = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Operands in and result out each use a valid/ready handshake.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > SUB_W_MAX) begin : g_bad_width
        $error("serial_sub_ctrl: WIDTH out of range");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bo;

    full_sb u_fsb (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .c  (r_brw),
        .d  (w_d),
        .bo (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= a_in;
                        r_b_sr   <= b_in;
                        r_res_sr <= '0;
                        r_brw    <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_res_sr <= (r_res_sr >> 1)
                              | (WIDTH'(w_d) << (WIDTH - 1));
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_brw    <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign diff       = out_valid ? r_res_sr : '0;
    assign borrow_out = out_valid & r_brw;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 against a cycle model, WIDTH=4/1 directed.
// Random operands, backpressure, busy churn and mid-op reset.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, borrow_out;
    logic [7:0] a_in, b_in, diff;
    logic       iv4, ir4, ov4, or4, bo4;
    logic [3:0] a4, b4, d4;
    logic       iv1, ir1, ov1, or1, bo1;
    logic [0:0] a1, b1, d1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a_in(a4), .b_in(b4), .out_valid(ov4),
        .out_ready(or4), .diff(d4), .borrow_out(bo4)
    );

    serial_sub_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a_in(a1), .b_in(b1), .out_valid(ov1),
        .out_ready(or1), .diff(d1), .borrow_out(bo1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model of the WIDTH=8 instance: a pending result becomes visible
    // WIDTH edges after the accept edge and stays until taken.
    int         e = 0;
    int         m_t = 0;
    bit         m_busy = 0;
    bit         m_have = 0;
    logic [7:0] m_d = 0;
    logic       m_b = 0;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_t    = e + 8;
                m_d    = a_in - b_in;
                m_b    = (a_in < b_in);
            end
        end else if (m_have && out_ready) begin
            m_busy = 0;
        end
        m_have = m_busy && (e >= m_t);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model in_ready", in_ready, !m_busy);
            chk("model out_valid", out_valid, m_have);
            chk("model diff", diff, m_have ? m_d : 8'h00);
            chk("model borrow", borrow_out, m_have & m_b);
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit churn, input bit lit,
                       input logic [7:0] ed, input logic eb);
        int         n;
        logic [7:0] seen;
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            if (churn) begin
                in_valid = 1'b1;
                a_in     = 8'($urandom);
                b_in     = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency8", n, 8);
        seen = diff;
        if (lit) begin
            chk("lit diff", diff, ed);
            chk("lit borrow", borrow_out, eb);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold valid", out_valid, 1'b1);
            chk("hold diff", diff, seen);
            chk("hold in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("taken in_ready", in_ready, 1'b1);
        chk("taken out_valid", out_valid, 1'b0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int n;
        iv4 = 1'b1; a4 = a; b4 = b;
        @(posedge clk); #1;
        iv4 = 1'b0;
        n = 0;
        while (ov4 !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (n != 4) chk("latency4", n, 4);
        chk("w4 diff", d4, 4'((a - b) & 4'hF));
        chk("w4 borrow", bo4, (a < b));
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    task automatic op1(input logic a, input logic b);
        int n;
        iv1 = 1'b1; a1 = a; b1 = b;
        @(posedge clk); #1;
        iv1 = 1'b0;
        n = 0;
        while (ov1 !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, 1);
        chk("w1 diff", d1, a ^ b);
        chk("w1 borrow", bo1, (!a && b));
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        chk("w1 in_ready", ir1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a_in = 0; b_in = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst diff", diff, 8'h00);
        chk("rst borrow", borrow_out, 1'b0);

        op8(8'h5A, 8'h3C, 0, 0, 1, 8'h1E, 1'b0);
        op8(8'h00, 8'h01, 0, 0, 1, 8'hFF, 1'b1);
        op8(8'h80, 8'h7F, 0, 0, 1, 8'h01, 1'b0);
        op8(8'hFF, 8'hFF, 5, 0, 1, 8'h00, 1'b0);
        op8(8'hC3, 8'h42, 0, 1, 1, 8'h81, 1'b0);

        in_valid = 1'b1; a_in = 8'h33; b_in = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst in_ready", in_ready, 1'b1);
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst diff", diff, 8'h00);
        op8(8'h10, 8'h20, 0, 0, 1, 8'hF0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            op8(8'($urandom), 8'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 0, 8'h00, 1'b0);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(4'(a), 4'(b));

        op1(1'b0, 1'b1);
        chk("w1 pin 0-1 diff", {31'd0, d1}, 32'd0);
        op1(1'b0, 1'b0);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
